// File: rtl/cnoc_axi_arb.sv
// rtl/cnoc_axi_arb.sv - NUM_M-to-1 CNOC AXI arbiter; CNOC_AXI_ARB_QOS_EN enables QoS-priority arbitration
package cnoc_axi_pkg;
    localparam int AXI_IDW = 8;
    localparam int AXI_AW  = 32;
    localparam int AXI_DW  = 64;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [AXI_AW-1:0]  addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic [3:0]         qos;
    } cnoc_ax_s;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
    } cnoc_w_s;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [1:0]         resp;
    } cnoc_b_s;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [AXI_DW-1:0]  data;
        logic [1:0]         resp;
        logic               last;
    } cnoc_r_s;

    typedef struct packed {
        cnoc_ax_s aw;
        logic     aw_valid;
        cnoc_w_s  w;
        logic     w_valid;
        logic     b_ready;
        cnoc_ax_s ar;
        logic     ar_valid;
        logic     r_ready;
    } cnoc_req_s;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        cnoc_b_s b;
        logic    b_valid;
        logic    ar_ready;
        cnoc_r_s r;
        logic    r_valid;
    } cnoc_resp_s;
endpackage

module cnoc_axi_arb_ch
    import cnoc_axi_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [NUM_M-1:0] req_valid,
    input  cnoc_ax_s         req_ax [NUM_M],
    input  logic             cap_en,
    output logic [NUM_M-1:0] req_ready,
    output logic             out_valid,
    output cnoc_ax_s         out_ax,
    input  logic             out_ready
);
    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, win_q, win;
    logic [NUM_M-1:0] eligible;
    logic             any_req;
    cnoc_ax_s         ax_q, win_ax;

`ifdef CNOC_AXI_ARB_QOS_EN
    logic [3:0] max_qos;
    always_comb begin
        max_qos  = '0;
        eligible = '0;
        for (int i = 0; i < NUM_M; i++)
            if (req_valid[i] && req_ax[i].qos > max_qos)
                max_qos = req_ax[i].qos;
        for (int i = 0; i < NUM_M; i++)
            eligible[i] = req_valid[i] && (req_ax[i].qos == max_qos);
    end
`else
    assign eligible = req_valid;
`endif

    // first eligible master scanning upward from rr_ptr, wrapping at NUM_M
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_M)
                idx = idx - NUM_M;
            if (!any_req && eligible[idx]) begin
                any_req = 1'b1;
                win     = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        win_ax = req_ax[win];
        win_ax.id = {win, req_ax[win].id[AXI_IDW-IDX_W-1:0]};
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        out_valid = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req && cap_en) begin
                    req_ready[win] = 1'b1;
                    state_d        = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            ax_q     <= '0;
        end else begin
            state_q <= state_d;
            if (|req_ready) begin
                win_q <= win;
                ax_q  <= win_ax;
            end
            if (state_q == ARB_HOLD && out_ready)
                rr_ptr_q <= (win_q == IDX_W'(NUM_M-1)) ? '0 : win_q + IDX_W'(1);
        end
    end

    assign out_ax = ax_q;
endmodule

module cnoc_axi_arb
    import cnoc_axi_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  cnoc_req_s  m_req  [NUM_M],
    output cnoc_resp_s m_resp [NUM_M],
    output cnoc_req_s  s_req,
    input  cnoc_resp_s s_resp
);
    localparam int IDX_W = $clog2(NUM_M);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);

    logic [NUM_M-1:0] aw_valid_v, ar_valid_v, aw_ready_v, ar_ready_v;
    cnoc_ax_s         aw_ax [NUM_M];
    cnoc_ax_s         ar_ax [NUM_M];
    cnoc_ax_s         aw_out, ar_out;
    logic             aw_out_valid, ar_out_valid;

    logic [IDX_W-1:0] fifo_q [WFIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [IDX_W-1:0] head, push_idx, b_idx, r_idx;
    logic             empty, full, push, pop, aw_cap_en;
    cnoc_w_s          s_w;
    logic             s_w_valid;

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            aw_valid_v[i] = m_req[i].aw_valid;
            ar_valid_v[i] = m_req[i].ar_valid;
            aw_ax[i]      = m_req[i].aw;
            ar_ax[i]      = m_req[i].ar;
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PTR_W+1)'(WFIFO_DEPTH));
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        s_w       = '0;
        s_w_valid = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (head == IDX_W'(i)) begin
                s_w       = m_req[i].w;
                s_w_valid = m_req[i].w_valid && !empty;
            end
        end
    end

    // a W last leaving the FIFO frees a slot the same cycle, so a full FIFO can still capture
    assign pop       = s_w_valid && s_resp.w_ready && s_w.last;
    assign aw_cap_en = arst_n && (!full || pop);
    assign push      = |aw_ready_v;

    always_comb begin
        push_idx = '0;
        for (int i = 0; i < NUM_M; i++)
            if (aw_ready_v[i])
                push_idx = IDX_W'(i);
    end

    cnoc_axi_arb_ch #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_aw_arb (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (aw_valid_v),
        .req_ax    (aw_ax),
        .cap_en    (aw_cap_en),
        .req_ready (aw_ready_v),
        .out_valid (aw_out_valid),
        .out_ax    (aw_out),
        .out_ready (s_resp.aw_ready)
    );

    cnoc_axi_arb_ch #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_ar_arb (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (ar_valid_v),
        .req_ax    (ar_ax),
        .cap_en    (arst_n),
        .req_ready (ar_ready_v),
        .out_valid (ar_out_valid),
        .out_ax    (ar_out),
        .out_ready (s_resp.ar_ready)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < WFIFO_DEPTH; i++)
                fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_idx;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    assign b_idx = s_resp.b.id[AXI_IDW-1 -: IDX_W];
    assign r_idx = s_resp.r.id[AXI_IDW-1 -: IDX_W];

    // responses whose index names no master are sunk rather than forwarded
    always_comb begin
        s_req          = '0;
        s_req.aw       = aw_out;
        s_req.aw_valid = aw_out_valid;
        s_req.ar       = ar_out;
        s_req.ar_valid = ar_out_valid;
        s_req.w        = s_w;
        s_req.w_valid  = s_w_valid;
        s_req.b_ready  = arst_n && (int'(b_idx) >= NUM_M);
        s_req.r_ready  = arst_n && (int'(r_idx) >= NUM_M);
        for (int i = 0; i < NUM_M; i++) begin
            m_resp[i]          = '0;
            m_resp[i].aw_ready = aw_ready_v[i];
            m_resp[i].ar_ready = ar_ready_v[i];
            m_resp[i].w_ready  = s_resp.w_ready && !empty && (head == IDX_W'(i));
            m_resp[i].b        = s_resp.b;
            m_resp[i].b.id[AXI_IDW-1 -: IDX_W] = '0;
            m_resp[i].b_valid  = arst_n && s_resp.b_valid && (b_idx == IDX_W'(i));
            m_resp[i].r        = s_resp.r;
            m_resp[i].r.id[AXI_IDW-1 -: IDX_W] = '0;
            m_resp[i].r_valid  = arst_n && s_resp.r_valid && (r_idx == IDX_W'(i));
            if (arst_n && b_idx == IDX_W'(i))
                s_req.b_ready = m_req[i].b_ready;
            if (arst_n && r_idx == IDX_W'(i))
                s_req.r_ready = m_req[i].r_ready;
        end
    end
endmodule

// File: tb/tb_cnoc_axi_arb.sv
// tb/tb_cnoc_axi_arb.sv - directed self-checking bench for cnoc_axi_arb
module tb_cnoc_axi_arb;
    import cnoc_axi_pkg::*;

    logic       clk = 1'b0;
    logic       arst_n;
    cnoc_req_s  m_req  [2];
    cnoc_resp_s m_resp [2];
    cnoc_req_s  s_req;
    cnoc_resp_s s_resp;
    int         checks = 0;
    int         errors = 0;
    int         qos_en;
    int         w;

    always #5 clk = ~clk;

    cnoc_axi_arb #(.NUM_M(2), .WFIFO_DEPTH(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef CNOC_AXI_ARB_QOS_EN
        qos_en = 1;
`else
        qos_en = 0;
`endif
        m_req[0] = '0;
        m_req[1] = '0;
        s_resp   = '0;
        arst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aw_valid", s_req.aw_valid, 0);
        chk("rst_ar_valid", s_req.ar_valid, 0);
        chk("rst_w_valid", s_req.w_valid, 0);
        chk("rst_b_ready", s_req.b_ready, 0);
        chk("rst_r_ready", s_req.r_ready, 0);
        chk("rst_aw_ready0", m_resp[0].aw_ready, 0);

        next_cycle();
        arst_n = 1'b1;
        s_resp.aw_ready = 1'b1;
        s_resp.ar_ready = 1'b1;
        s_resp.w_ready  = 1'b1;

        // single write from m0, W offered before AW is captured
        m_req[0].aw_valid = 1'b1;
        m_req[0].aw.id    = 8'h01;
        m_req[0].aw.len   = 8'd3;
        m_req[0].aw.addr  = 32'h1000;
        m_req[0].w_valid  = 1'b1;
        m_req[0].w.data   = 64'hA0;
        m_req[0].w.last   = 1'b0;
        @(negedge clk);
        chk("wr_aw_ready0", m_resp[0].aw_ready, 1);
        chk("wr_aw_ready1", m_resp[1].aw_ready, 0);
        chk("wr_early_w_valid", s_req.w_valid, 0);
        chk("wr_early_w_ready", m_resp[0].w_ready, 0);
        chk("wr_aw_lat", s_req.aw_valid, 0);
        next_cycle();
        m_req[0].aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_req[0].w.data = 64'hA0 + 64'(b);
            m_req[0].w.last = (b == 3);
            @(negedge clk);
            if (b == 0) begin
                chk("wr_s_aw_valid", s_req.aw_valid, 1);
                chk("wr_s_aw_id", s_req.aw.id, 8'h01);
                chk("wr_s_aw_len", s_req.aw.len, 3);
                chk("wr_s_aw_addr", s_req.aw.addr, 32'h1000);
            end
            chk("wr_w_valid", s_req.w_valid, 1);
            chk("wr_w_data", s_req.w.data, 64'hA0 + 64'(b));
            chk("wr_w_ready0", m_resp[0].w_ready, 1);
            chk("wr_w_ready1", m_resp[1].w_ready, 0);
            next_cycle();
        end
        m_req[0].w_valid = 1'b0;
        m_req[0].w.last  = 1'b0;
        @(negedge clk);
        chk("wr_aw_done", s_req.aw_valid, 0);
        chk("wr_w_ready_empty", m_resp[0].w_ready, 0);
        s_resp.b_valid   = 1'b1;
        s_resp.b.id      = 8'h01;
        m_req[0].b_ready = 1'b1;
        #1;
        chk("b_valid0", m_resp[0].b_valid, 1);
        chk("b_id0", m_resp[0].b.id, 8'h01);
        chk("b_valid1", m_resp[1].b_valid, 0);
        chk("b_s_ready", s_req.b_ready, 1);
        next_cycle();
        s_resp.b_valid = 1'b0;

        // both masters request AR continuously
        m_req[0].ar_valid = 1'b1;
        m_req[0].ar.id    = 8'h02;
        m_req[0].ar.qos   = 4'd2;
        m_req[1].ar_valid = 1'b1;
        m_req[1].ar.id    = 8'h03;
        m_req[1].ar.qos   = 4'd5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            w = (qos_en != 0) ? 1 : ((k % 4) < 2 ? 0 : 1);
            if (k % 2 == 0) begin
                chk("ar_ready0", m_resp[0].ar_ready, (w == 0));
                chk("ar_ready1", m_resp[1].ar_ready, (w == 1));
                chk("ar_s_idle", s_req.ar_valid, 0);
            end else begin
                chk("ar_s_valid", s_req.ar_valid, 1);
                chk("ar_s_id", s_req.ar.id, (w == 1) ? 8'h83 : 8'h02);
                chk("ar_ready_hold", m_resp[0].ar_ready | m_resp[1].ar_ready, 0);
            end
            next_cycle();
        end
        m_req[0].ar_valid = 1'b0;
        m_req[1].ar_valid = 1'b0;

        // R routing by id top bit, with backpressure from m1
        s_resp.r_valid   = 1'b1;
        s_resp.r.id      = 8'h81;
        s_resp.r.data    = 64'hBEEF;
        m_req[0].r_ready = 1'b1;
        m_req[1].r_ready = 1'b1;
        @(negedge clk);
        chk("r1_valid", m_resp[1].r_valid, 1);
        chk("r1_id", m_resp[1].r.id, 8'h01);
        chk("r1_data", m_resp[1].r.data, 64'hBEEF);
        chk("r1_valid0", m_resp[0].r_valid, 0);
        chk("r1_s_ready", s_req.r_ready, 1);
        next_cycle();
        m_req[1].r_ready = 1'b0;
        @(negedge clk);
        chk("r1_stall_ready", s_req.r_ready, 0);
        chk("r1_stall_valid", m_resp[1].r_valid, 1);
        next_cycle();
        m_req[1].r_ready = 1'b1;
        s_resp.r.id      = 8'h04;
        @(negedge clk);
        chk("r0_valid", m_resp[0].r_valid, 1);
        chk("r0_id", m_resp[0].r.id, 8'h04);
        chk("r0_valid1", m_resp[1].r_valid, 0);
        chk("r0_s_ready", s_req.r_ready, 1);
        next_cycle();
        s_resp.r_valid = 1'b0;

        // fill the write-grant FIFO with W withheld
        m_req[0].aw_valid = 1'b1;
        m_req[0].aw.id    = 8'h07;
        m_req[0].aw.len   = 8'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("fifo_aw_ready", m_resp[0].aw_ready, (k < 8 && k % 2 == 0));
            next_cycle();
        end
        m_req[0].w_valid = 1'b1;
        m_req[0].w.last  = 1'b1;
        m_req[0].w.data  = 64'h55;
        @(negedge clk);
        chk("fifo_pop_w_valid", s_req.w_valid, 1);
        chk("fifo_pop_aw_ready", m_resp[0].aw_ready, 1);
        next_cycle();

        // reset while AW is held and a W burst is half-sent
        m_req[0].aw.id    = 8'h05;
        m_req[1].aw_valid = 1'b1;
        m_req[1].aw.id    = 8'h06;
        m_req[0].w.last   = 1'b0;
        @(negedge clk);
        chk("pre_rst_aw_valid", s_req.aw_valid, 1);
        chk("pre_rst_w_valid", s_req.w_valid, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_aw_valid", s_req.aw_valid, 0);
        chk("mid_rst_w_valid", s_req.w_valid, 0);
        chk("mid_rst_aw_ready0", m_resp[0].aw_ready, 0);
        chk("mid_rst_aw_ready1", m_resp[1].aw_ready, 0);
        chk("mid_rst_w_ready0", m_resp[0].w_ready, 0);
        chk("mid_rst_b_ready", s_req.b_ready, 0);
        next_cycle();
        m_req[0].w_valid = 1'b0;
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_aw_ready0", m_resp[0].aw_ready, 1);
        chk("post_rst_aw_ready1", m_resp[1].aw_ready, 0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_aw_valid", s_req.aw_valid, 1);
        chk("post_rst_aw_id", s_req.aw.id, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
